// File: rtl/crossing_pkg.sv
// Shared types and lamp encodings for the level-crossing signal controller.
package crossing_pkg;

  typedef enum logic [1:0] {GREEN, RED, YELLOW, FAULT} state_t;

  // Lamp vectors are ordered {green, yellow, red}.
  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

endpackage

// File: rtl/crossing_timer.sv
// Loadable down-counter: load_i sets it to MAX, dec_i counts down and holds at zero.
module crossing_timer #(
  parameter int unsigned MAX = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned W = $clog2(MAX + 1) + 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(MAX);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/crossing_ctrl.sv
// Multi-track level-crossing controller: Moore lamp FSM with yellow clearance,
// passage counting and a stuck-sensor fault mode with flashing red.
module crossing_ctrl #(
  parameter int unsigned NUM_TRACKS     = 2,
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned FLASH_CYCLES   = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_TRACKS-1:0] train_i,
  input  logic                  clear_fault_i,
  output logic                  green_o,
  output logic                  yellow_o,
  output logic                  red_o,
  output logic                  fault_o,
  output logic [CNT_W-1:0]      pass_count_o
);

  import crossing_pkg::*;

  localparam int unsigned StuckW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [StuckW-1:0] StuckLast = StuckW'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [StuckW-1:0]  stuck_q, stuck_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic               flash_q, flash_d;
  logic               yel_load, yel_dec, yel_zero;
  logic               fl_load, fl_dec, fl_zero;
  logic               any_train;
  logic [2:0]         lamps;

  assign any_train = |train_i;

  crossing_timer #(
    .MAX (YELLOW_CYCLES - 1)
  ) u_yellow_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (yel_load),
    .dec_i  (yel_dec),
    .zero_o (yel_zero)
  );

  crossing_timer #(
    .MAX (FLASH_CYCLES - 1)
  ) u_flash_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (fl_load),
    .dec_i  (fl_dec),
    .zero_o (fl_zero)
  );

  always_comb begin
    state_d  = state_q;
    stuck_d  = stuck_q;
    pass_d   = pass_q;
    flash_d  = flash_q;
    yel_load = 1'b0;
    yel_dec  = 1'b0;
    fl_load  = 1'b0;
    fl_dec   = 1'b0;
    case (state_q)
      GREEN: begin
        if (any_train) begin
          state_d = RED;
          stuck_d = '0;
        end
      end
      RED: begin
        if (!any_train) begin
          state_d  = YELLOW;
          yel_load = 1'b1;
          pass_d   = pass_q + CNT_W'(1);
        end else if (stuck_q == StuckLast) begin
          state_d = FAULT;
          fl_load = 1'b1;
          flash_d = 1'b1;
        end else begin
          stuck_d = stuck_q + StuckW'(1);
        end
      end
      YELLOW: begin
        // A re-arrival wins over an expiring clearance timer.
        if (any_train) begin
          state_d = RED;
          stuck_d = '0;
        end else if (yel_zero) begin
          state_d = GREEN;
        end else begin
          yel_dec = 1'b1;
        end
      end
      FAULT: begin
        if (clear_fault_i && !any_train) begin
          state_d = RED;
          stuck_d = '0;
        end else if (fl_zero) begin
          flash_d = ~flash_q;
          fl_load = 1'b1;
        end else begin
          fl_dec = 1'b1;
        end
      end
      default: state_d = GREEN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= GREEN;
      stuck_q <= '0;
      pass_q  <= '0;
      flash_q <= 1'b1;
    end else begin
      state_q <= state_d;
      stuck_q <= stuck_d;
      pass_q  <= pass_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    lamps = LAMP_GREEN;
    case (state_q)
      GREEN:   lamps = LAMP_GREEN;
      RED:     lamps = LAMP_RED;
      YELLOW:  lamps = LAMP_YELLOW;
      FAULT:   lamps = {2'b00, flash_q};
      default: lamps = LAMP_GREEN;
    endcase
  end

  assign {green_o, yellow_o, red_o} = lamps;
  assign fault_o      = (state_q == FAULT);
  assign pass_count_o = pass_q;

endmodule

// File: tb/tb_crossing_ctrl.sv
// Directed bench for crossing_ctrl with a phase/age-based reference model checked every cycle.
module tb_crossing_ctrl;

  localparam int unsigned YC = 3;
  localparam int unsigned TC = 8;
  localparam int unsigned FC = 2;

  logic       clk, rst, clear_fault;
  logic [1:0] train;
  logic       g, y, r, flt, g2, y2, r2, flt2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  crossing_ctrl #(
    .NUM_TRACKS(2), .YELLOW_CYCLES(YC), .TIMEOUT_CYCLES(TC), .FLASH_CYCLES(FC), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .train_i(train), .clear_fault_i(clear_fault),
    .green_o(g), .yellow_o(y), .red_o(r), .fault_o(flt), .pass_count_o(cnt)
  );

  // Narrow-counter copy shares all stimulus; used to observe counter wrap.
  crossing_ctrl #(
    .NUM_TRACKS(2), .YELLOW_CYCLES(YC), .TIMEOUT_CYCLES(TC), .FLASH_CYCLES(FC), .CNT_W(2)
  ) dut_w (
    .clk_i(clk), .rst_i(rst), .train_i(train), .clear_fault_i(clear_fault),
    .green_o(g2), .yellow_o(y2), .red_o(r2), .fault_o(flt2), .pass_count_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: mode plus how long it has been in the mode.
  int          mode;  // 0 green, 1 red, 2 yellow, 3 fault
  int          red_age, yel_age, fault_age;
  int unsigned passes;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = 0; red_age = 0; yel_age = 0; fault_age = 0; passes = 0;
    end else begin
      case (mode)
        0: if (train != 2'b00) begin mode = 1; red_age = 0; end
        1: begin
          if (train == 2'b00) begin
            mode = 2; yel_age = 0; passes = passes + 1;
          end else if (red_age + 1 == TC) begin
            mode = 3; fault_age = 0;
          end else begin
            red_age++;
          end
        end
        2: begin
          if (train != 2'b00) begin mode = 1; red_age = 0; end
          else if (yel_age + 1 == YC) mode = 0;
          else yel_age++;
        end
        default: begin
          if (clear_fault && train == 2'b00) begin mode = 1; red_age = 0; end
          else fault_age++;
        end
      endcase
    end
  end

  function automatic logic [2:0] exp_lamps();
    case (mode)
      0: return 3'b100;
      1: return 3'b001;
      2: return 3'b010;
      default: return {2'b00, ((fault_age / FC) % 2) == 0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      logic [15:0] p16;
      logic [1:0]  p2;
      p16 = passes[15:0];
      p2  = passes[1:0];
      check("lamps", {29'd0, g, y, r}, {29'd0, exp_lamps()});
      check("lamps_w", {29'd0, g2, y2, r2}, {29'd0, exp_lamps()});
      check("fault", {31'd0, flt}, {31'd0, mode == 3});
      check("pass_count", {16'd0, cnt}, {16'd0, p16});
      check("pass_count_w", {30'd0, cnt2}, {30'd0, p2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [2:0] lamps, input logic f);
    check(name, {29'd0, g, y, r}, {29'd0, lamps});
    check({name, "_fault"}, {31'd0, flt}, {31'd0, f});
  endtask

  initial begin
    logic [5:0] flash_pat;
    flash_pat   = 6'b110011;
    rst         = 1'b1;
    train       = 2'b00;
    clear_fault = 1'b0;
    #20;
    rst = 1'b0;
    #1;
    lit("reset", 3'b100, 1'b0);
    check("reset_cnt", {16'd0, cnt}, 32'd0);

    // Single passage
    tick();
    train = 2'b01;
    tick();
    lit("p1_red", 3'b001, 1'b0);
    tick(); tick();
    train = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("p1_yellow", 3'b010, 1'b0);
    end
    check("p1_cnt", {16'd0, cnt}, 32'd1);
    tick();
    lit("p1_green", 3'b100, 1'b0);

    // Re-arrival in the 2nd yellow cycle, then overlapping tracks
    train = 2'b01;
    tick();
    train = 2'b00;
    tick();
    check("p2_cnt", {16'd0, cnt}, 32'd2);
    tick();
    lit("rearr_yel2", 3'b010, 1'b0);
    train = 2'b10;
    tick();
    lit("rearr_red", 3'b001, 1'b0);
    check("rearr_cnt", {16'd0, cnt}, 32'd2);
    train = 2'b11; tick();
    train = 2'b01; tick();
    check("overlap_cnt_hold", {16'd0, cnt}, 32'd2);
    train = 2'b00; tick();
    check("overlap_cnt", {16'd0, cnt}, 32'd3);
    check("wrap_pre", {30'd0, cnt2}, 32'd3);
    tick(); tick(); tick();
    lit("overlap_green", 3'b100, 1'b0);

    // Stuck sensor
    train = 2'b01;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      lit("stuck_red", 3'b001, 1'b0);
    end
    tick();
    for (int i = 5; i >= 0; i--) begin
      lit("flash", {2'b00, flash_pat[i]}, 1'b1);
      if (i > 0) tick();
    end
    clear_fault = 1'b1;
    tick();
    check("clear_with_train", {31'd0, flt}, 32'd1);
    train = 2'b00;
    tick();
    clear_fault = 1'b0;
    lit("clear_red", 3'b001, 1'b0);
    tick();
    lit("clear_yellow", 3'b010, 1'b0);
    check("cnt_after_fault", {16'd0, cnt}, 32'd4);
    check("wrap", {30'd0, cnt2}, 32'd0);

    // Asynchronous reset in YELLOW
    #1 rst = 1'b1;
    #1 lit("rst_yellow", 3'b100, 1'b0);
    check("rst_yellow_cnt", {16'd0, cnt}, 32'd0);
    rst = 1'b0;

    // Asynchronous reset in FAULT
    train = 2'b10;
    for (int i = 0; i < 9; i++) tick();
    check("fault_again", {31'd0, flt}, 32'd1);
    #1 rst = 1'b1;
    #1 lit("rst_fault", 3'b100, 1'b0);
    rst   = 1'b0;
    train = 2'b00;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
